// File: rtl/stat_rmw_ctrl.sv
// stat_rmw_ctrl: read-modify-write sequencer for the icache status register file.
// Serialises flush/fill/invalidate/touch onto the single status-file port under freeze back-pressure.
module stat_rmw_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_flush_req,
  input  logic                  i_fill_req,
  input  logic [ADDR_WIDTH-1:0] i_fill_addr,
  input  logic                  i_inv_req,
  input  logic [ADDR_WIDTH-1:0] i_inv_addr,
  input  logic                  i_touch_req,
  input  logic [ADDR_WIDTH-1:0] i_touch_addr,
  output logic                  o_flush_done,
  output logic                  o_fill_ack,
  output logic                  o_inv_ack,
  output logic                  o_touch_ack,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_srf_addr,
  output logic                  o_srf_use,
  output logic                  o_srf_block_valid,
  output logic                  o_srf_spare_bit,
  output logic                  o_srf_wen,
  output logic                  o_srf_valid,
  input  logic                  i_srf_use,
  input  logic                  i_srf_block_valid,
  input  logic                  i_srf_spare_bit,
  input  logic                  i_srf_valid,
  input  logic                  i_srf_freeze
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_ACK, S_FLUSH, S_FDONE} state_t;
  typedef enum logic [1:0] {OP_FILL, OP_INV, OP_TOUCH} op_t;
  state_t                r_state, w_next;
  op_t                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr, r_ptr;
  logic                  r_rd_valid, r_rd_spare;
  logic                  w_unused_use;
  // Every op overwrites the use bit, so the read-back use bit is never needed.
  assign w_unused_use = i_srf_use;
  always_ff @(posedge clk or posedge arst)
    if (arst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_op       <= OP_FILL;
      r_addr     <= '0;
      r_ptr      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_spare <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (i_flush_req) r_ptr <= '0;
        else if (i_fill_req) begin
          r_op   <= OP_FILL;
          r_addr <= i_fill_addr;
        end else if (i_inv_req) begin
          r_op   <= OP_INV;
          r_addr <= i_inv_addr;
        end else if (i_touch_req) begin
          r_op   <= OP_TOUCH;
          r_addr <= i_touch_addr;
        end
      end
      if (r_state == S_RWAIT && i_srf_valid) begin
        r_rd_valid <= i_srf_block_valid;
        r_rd_spare <= i_srf_spare_bit;
      end
      if (r_state == S_FLUSH && !i_srf_freeze) r_ptr <= r_ptr + 1'b1;
    end
  end
  // Outputs decode from registered state only, so they stay frozen while the file stalls.
  always_comb begin
    w_next            = r_state;
    o_busy            = r_state != S_IDLE;
    o_srf_valid       = 1'b0;
    o_srf_wen         = 1'b0;
    o_srf_addr        = '0;
    o_srf_use         = 1'b0;
    o_srf_block_valid = 1'b0;
    o_srf_spare_bit   = 1'b0;
    o_fill_ack        = 1'b0;
    o_inv_ack         = 1'b0;
    o_touch_ack       = 1'b0;
    o_flush_done      = 1'b0;
    case (r_state)
      S_IDLE: w_next = i_flush_req ? S_FLUSH : (i_fill_req || i_inv_req || i_touch_req) ? S_RD : S_IDLE;
      S_RD: begin
        o_srf_valid = 1'b1;
        o_srf_addr  = r_addr;
        w_next      = i_srf_freeze ? S_RD : S_RWAIT;
      end
      S_RWAIT: w_next = i_srf_valid ? S_WR : S_RWAIT;
      S_WR: begin
        o_srf_valid       = 1'b1;
        o_srf_wen         = 1'b1;
        o_srf_addr        = r_addr;
        o_srf_use         = r_op != OP_INV;
        o_srf_block_valid = r_op == OP_FILL || (r_op == OP_TOUCH && r_rd_valid);
        o_srf_spare_bit   = r_rd_spare;
        w_next            = i_srf_freeze ? S_WR : S_ACK;
      end
      S_ACK: begin
        o_fill_ack  = r_op == OP_FILL;
        o_inv_ack   = r_op == OP_INV;
        o_touch_ack = r_op == OP_TOUCH;
        w_next      = S_IDLE;
      end
      S_FLUSH: begin
        o_srf_valid = 1'b1;
        o_srf_wen   = 1'b1;
        o_srf_addr  = r_ptr;
        w_next      = (!i_srf_freeze && &r_ptr) ? S_FDONE : S_FLUSH;
      end
      S_FDONE: begin
        o_flush_done = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_stat_rmw_ctrl.sv
// tb_stat_rmw_ctrl: drives stat_rmw_ctrl against a behavioural status file and checks each pass
// against expected command streams, acks and latencies derived from the operation rules.
module tb_stat_rmw_ctrl;
  localparam int AW = 3;
  localparam int N  = 1 << AW;
  typedef struct packed {logic wen; logic [AW-1:0] addr; logic [2:0] data;} cmd_t;
  logic clk = 1'b0, arst = 1'b1;
  logic i_flush_req = 0, i_fill_req = 0, i_inv_req = 0, i_touch_req = 0;
  logic [AW-1:0] i_fill_addr = '0, i_inv_addr = '0, i_touch_addr = '0;
  logic o_flush_done, o_fill_ack, o_inv_ack, o_touch_ack, o_busy;
  logic [AW-1:0] o_srf_addr;
  logic o_srf_use, o_srf_block_valid, o_srf_spare_bit, o_srf_wen, o_srf_valid;
  logic i_srf_use = 0, i_srf_block_valid = 0, i_srf_spare_bit = 0, i_srf_valid = 0, i_srf_freeze = 0;
  stat_rmw_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .arst(arst),
    .i_flush_req(i_flush_req), .i_fill_req(i_fill_req), .i_fill_addr(i_fill_addr),
    .i_inv_req(i_inv_req), .i_inv_addr(i_inv_addr),
    .i_touch_req(i_touch_req), .i_touch_addr(i_touch_addr),
    .o_flush_done(o_flush_done), .o_fill_ack(o_fill_ack), .o_inv_ack(o_inv_ack),
    .o_touch_ack(o_touch_ack), .o_busy(o_busy),
    .o_srf_addr(o_srf_addr), .o_srf_use(o_srf_use), .o_srf_block_valid(o_srf_block_valid),
    .o_srf_spare_bit(o_srf_spare_bit), .o_srf_wen(o_srf_wen), .o_srf_valid(o_srf_valid),
    .i_srf_use(i_srf_use), .i_srf_block_valid(i_srf_block_valid), .i_srf_spare_bit(i_srf_spare_bit),
    .i_srf_valid(i_srf_valid), .i_srf_freeze(i_srf_freeze)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic [2:0] mem [N];
  logic [2:0] pre [N];
  cmd_t cmds[$];
  int extra_lat = 0, frz_pct = 0, frz_idx = 0, frz_n = 0, ack_cyc = 0, stalls = 0;
  bit spur = 0, withdraw = 0, keep_losers = 0, timed_out = 0;
  logic [3:0] ack_seen, ack_after;
  logic busy_after;
  function automatic logic [12:0] outs();
    return {o_flush_done, o_fill_ack, o_inv_ack, o_touch_ack, o_busy, o_srf_addr,
            o_srf_use, o_srf_block_valid, o_srf_spare_bit, o_srf_wen, o_srf_valid};
  endfunction
  function automatic logic [3:0] acks();
    return {o_flush_done, o_fill_ack, o_inv_ack, o_touch_ack};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Acts as the status file cycle by cycle until an ack/done pulse, then samples one cycle more.
  task automatic run_pass(input int budget);
    int c = 0, rd_cnt = -1, cmd_idx = 0, frz_left = 0;
    bit frz_used = 0, held = 0, fr;
    logic [AW-1:0] rd_addr = '0;
    logic [12:0] snap = '0;
    cmd_t cm;
    cmds.delete();
    ack_seen = '0; ack_cyc = -1; stalls = 0; timed_out = 0;
    while (ack_seen == 0) begin
      if (c >= budget) begin
        timed_out = 1;
        break;
      end
      if (rd_cnt == 0) begin
        i_srf_valid = 1;
        {i_srf_use, i_srf_block_valid, i_srf_spare_bit} = mem[rd_addr];
        rd_cnt = -1;
      end else begin
        if (rd_cnt > 0) rd_cnt--;
        i_srf_valid = spur && rd_cnt < 0 && $urandom_range(1) == 1;
        {i_srf_use, i_srf_block_valid, i_srf_spare_bit} = 3'($urandom);
      end
      if (held) check("hold", 32'(outs()), 32'(snap));
      if (c == 1) begin
        check("busy_mid", 32'(o_busy), 32'd1);
        if (withdraw) {i_flush_req, i_fill_req, i_inv_req, i_touch_req} = '0;
      end
      if (o_srf_valid) begin
        if (!frz_used && frz_n > 0 && cmd_idx == frz_idx) begin
          frz_left = frz_n;
          frz_used = 1;
        end
        fr = frz_left > 0 || $urandom_range(99) < frz_pct;
        if (frz_left > 0) frz_left--;
      end else fr = $urandom_range(1) == 1;
      i_srf_freeze = fr;
      held = o_srf_valid && fr;
      snap = outs();
      if (held) stalls++;
      if (o_srf_valid && !fr) begin
        cm = {o_srf_wen, o_srf_addr, o_srf_use, o_srf_block_valid, o_srf_spare_bit};
        cmds.push_back(cm);
        if (o_srf_wen) mem[o_srf_addr] = cm.data;
        else begin
          rd_cnt  = extra_lat;
          rd_addr = o_srf_addr;
        end
        cmd_idx++;
      end
      if (acks() != 0) begin
        ack_seen = acks();
        ack_cyc  = c;
        if (keep_losers) begin
          if (ack_seen[3]) i_flush_req = 0;
          if (ack_seen[2]) i_fill_req = 0;
          if (ack_seen[1]) i_inv_req = 0;
          if (ack_seen[0]) i_touch_req = 0;
        end else {i_flush_req, i_fill_req, i_inv_req, i_touch_req} = '0;
      end
      @(negedge clk);
      c++;
    end
    busy_after   = o_busy;
    ack_after    = acks();
    i_srf_freeze = 0;
    i_srf_valid  = 0;
  endtask
  // Reference: winner by fixed priority, then the command stream and write data that op implies.
  task automatic do_pass(input string tag);
    logic [3:0] exp_ack = '0;
    logic [AW-1:0] a = '0;
    logic [2:0] old, nv;
    bit fl;
    pre = mem;
    fl = i_flush_req;
    if (i_flush_req) exp_ack = 4'b1000;
    else if (i_fill_req) begin exp_ack = 4'b0100; a = i_fill_addr; end
    else if (i_inv_req) begin exp_ack = 4'b0010; a = i_inv_addr; end
    else if (i_touch_req) begin exp_ack = 4'b0001; a = i_touch_addr; end
    old = pre[a];
    nv = exp_ack[2] ? {2'b11, old[0]} : exp_ack[1] ? {2'b00, old[0]} : {1'b1, old[1], old[0]};
    run_pass(300);
    check({tag, " timeout"}, 32'(timed_out), 32'd0);
    check({tag, " ack"}, 32'(ack_seen), 32'(exp_ack));
    check({tag, " ack_width"}, 32'(ack_after), 32'd0);
    check({tag, " idle_after"}, 32'(busy_after), 32'd0);
    if (fl) begin
      check({tag, " ncmd"}, 32'(cmds.size()), N);
      check({tag, " cycles"}, 32'(ack_cyc), 32'(N + 1 + stalls));
      if (cmds.size() == N)
        for (int i = 0; i < N; i++) check({tag, " wr"}, 32'(cmds[i]), 32'({1'b1, AW'(i), 3'b000}));
    end else begin
      check({tag, " ncmd"}, 32'(cmds.size()), 32'd2);
      check({tag, " cycles"}, 32'(ack_cyc), 32'(4 + stalls + extra_lat));
      if (cmds.size() == 2) begin
        check({tag, " rd"}, 32'({cmds[0].wen, cmds[0].addr}), 32'({1'b0, a}));
        check({tag, " wr"}, 32'(cmds[1]), 32'({1'b1, a, nv}));
      end
      check({tag, " mem"}, 32'(mem[a]), 32'(nv));
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) mem[i] = 3'($urandom);
    repeat (2) @(negedge clk);
    check("reset_outs", 32'(outs()), 32'd0);
    arst = 0;
    @(negedge clk);
    check("idle_outs", 32'(outs()), 32'd0);
    i_flush_req = 1;
    repeat (4) @(negedge clk);
    check("flush_busy", 32'(o_busy), 32'd1);
    #2 arst = 1;
    #1 check("arst_async", 32'(outs()), 32'd0);
    i_flush_req = 0;
    @(negedge clk);
    arst = 0;
    @(negedge clk);
    check("post_reset", 32'(outs()), 32'd0);
    i_flush_req = 1; frz_idx = 3; frz_n = 1;
    do_pass("flush");
    frz_n = 0;
    mem[5] = 3'b001;
    i_fill_req = 1; i_fill_addr = 3'd5;
    do_pass("fill5");
    mem[2] = 3'b000;
    i_touch_req = 1; i_touch_addr = 3'd2;
    do_pass("touch2");
    mem[7] = 3'b111;
    i_inv_req = 1; i_inv_addr = 3'd7; frz_idx = 1; frz_n = 3;
    do_pass("inv7");
    check("inv7 stalls", 32'(stalls), 32'd3);
    frz_n = 0; keep_losers = 1;
    i_fill_req = 1; i_fill_addr = 3'd1;
    i_inv_req = 1; i_inv_addr = 3'd3;
    i_touch_req = 1; i_touch_addr = 3'd4;
    do_pass("multi_fill");
    do_pass("multi_inv");
    do_pass("multi_touch");
    keep_losers = 0;
    for (int i = 0; i < N; i++) mem[i] = 3'($urandom);
    for (int k = 0; k < 40; k++) begin
      i_fill_addr  = AW'($urandom);
      i_inv_addr   = AW'($urandom);
      i_touch_addr = AW'($urandom);
      i_fill_req   = $urandom_range(1) == 1;
      i_inv_req    = $urandom_range(1) == 1;
      i_touch_req  = $urandom_range(1) == 1;
      i_flush_req  = $urandom_range(9) == 0;
      if (!(i_flush_req || i_fill_req || i_inv_req || i_touch_req)) i_touch_req = 1;
      extra_lat = $urandom_range(3);
      frz_pct   = 30;
      spur      = 1;
      withdraw  = $urandom_range(1) == 1;
      do_pass("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
